// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control with a fixed-latency mult/div busy tracker
// Ports: clk, reset (sync, active-low); id_rs/id_rt, idex_memRead/idex_rt (load-use check);
//   id_useHiLo, md_start (HI/LO hazard, mult/div launch); branch_taken, mem_busy;
//   outputs pcWrite, hzdWrite, if_flush, bubble, md_busy, md_done.
// Optional: define HZD_STATS_EN to add a 16-bit saturating stall_cnt output.
module hazard_ctrl #(
  parameter int MD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       idex_memRead,
  input  logic [4:0] idex_rt,
  input  logic       id_useHiLo,
  input  logic       md_start,
  input  logic       branch_taken,
  input  logic       mem_busy,
  output logic       pcWrite,
  output logic       hzdWrite,
  output logic       if_flush,
  output logic       bubble,
  output logic       md_busy,
  output logic       md_done
`ifdef HZD_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  typedef enum logic {MD_IDLE, MD_RUN} md_state_e;
  md_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       md_run, load_use, stall;
  logic [3:0] ctrl;
  assign md_run   = state_q == MD_RUN;
  assign load_use = idex_memRead && idex_rt != 5'd0 && (idex_rt == id_rs || idex_rt == id_rt);
  assign stall    = load_use || (md_run && id_useHiLo);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!md_run) begin
      if (md_start) begin
        state_d = MD_RUN;
        cnt_d   = 6'(MD_CYCLES - 1);
      end
    end else if (cnt_q == 6'd0) begin
      state_d = MD_IDLE;
    end else begin
      cnt_d = cnt_q - 6'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // {pcWrite, hzdWrite, if_flush, bubble}; a taken branch is dropped under any stall
  // because ID is frozen and will present it again.
  always_comb begin
    ctrl = !reset       ? 4'b0011 :
           mem_busy     ? 4'b0000 :
           stall        ? 4'b0001 :
           branch_taken ? 4'b1110 : 4'b1100;
  end
  assign {pcWrite, hzdWrite, if_flush, bubble} = ctrl;
  assign md_busy = reset && md_run;
  assign md_done = reset && md_run && cnt_q == 6'd0;
`ifdef HZD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  always_comb begin
    stall_cnt_d = (!hzdWrite && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= 16'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven and sequence checks of hazard_ctrl
module tb_hazard_ctrl;
  logic clk = 0;
  logic reset = 0;
  logic [4:0] id_rs = 0, id_rt = 0, idex_rt = 0;
  logic idex_memRead = 0, id_useHiLo = 0, md_start = 0, branch_taken = 0, mem_busy = 0;
  logic pc4, hz4, fl4, bb4, busy4, done4;
  logic pc32, hz32, fl32, bb32, busy32, done32;
`ifdef HZD_STATS_EN
  logic [15:0] sc4, sc32;
`endif
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.MD_CYCLES(4)) u4 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .idex_memRead(idex_memRead),
    .idex_rt(idex_rt), .id_useHiLo(id_useHiLo), .md_start(md_start), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pcWrite(pc4), .hzdWrite(hz4), .if_flush(fl4), .bubble(bb4),
    .md_busy(busy4), .md_done(done4)
`ifdef HZD_STATS_EN
    , .stall_cnt(sc4)
`endif
  );
  hazard_ctrl #(.MD_CYCLES(32)) u32 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .idex_memRead(idex_memRead),
    .idex_rt(idex_rt), .id_useHiLo(id_useHiLo), .md_start(md_start), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pcWrite(pc32), .hzdWrite(hz32), .if_flush(fl32), .bubble(bb32),
    .md_busy(busy32), .md_done(done32)
`ifdef HZD_STATS_EN
    , .stall_cnt(sc32)
`endif
  );
  typedef struct packed {
    logic [4:0] rs, rt;
    logic       mr;
    logic [4:0] xrt;
    logic       hl, br, mb;
    logic [3:0] exp;
  } vec_t;
  vec_t vt[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {id_rs, id_rt, idex_rt} = '0;
    {idex_memRead, id_useHiLo, md_start, branch_taken, mem_busy} = '0;
  endtask
  task automatic do_reset();
    clr();
    reset = 0;
    tick();
    tick();
    reset = 1;
    tick();
  endtask
  initial begin
    int nb, nd;
    // rs, rt, memRead, idex_rt, useHiLo, branch, mem_busy, {pc,hzd,flush,bubble}
    vt[0]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100};
    vt[1]  = '{5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 4'b0001};
    vt[2]  = '{5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 4'b0001};
    vt[3]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 4'b1100};
    vt[4]  = '{5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 4'b1100};
    vt[5]  = '{5'd3, 5'd4, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 4'b1100};
    vt[6]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'b1110};
    vt[7]  = '{5'd9, 5'd1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 4'b0001};
    vt[8]  = '{5'd9, 5'd1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, 4'b0000};
    vt[9]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'b0000};
    vt[10] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b1100};
    vt[11] = '{5'd31, 5'd31, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0, 4'b0001};
    tick();
    chk("reset_ctrl", {pc4, hz4, fl4, bb4}, 4'b0011);
    chk("reset_md", {busy4, done4}, 2'b00);
    reset = 1;
    tick();
    for (int i = 0; i < 12; i++) begin
      {id_rs, id_rt, idex_memRead, idex_rt, id_useHiLo, branch_taken, mem_busy} =
        {vt[i].rs, vt[i].rt, vt[i].mr, vt[i].xrt, vt[i].hl, vt[i].br, vt[i].mb};
      #1;
      chk($sformatf("vec%0d", i), {pc4, hz4, fl4, bb4}, vt[i].exp);
    end
    clr();
    tick();
    md_start = 1;
    id_useHiLo = 1;
    #1;
    chk("md_c0", {busy4, done4, pc4, bb4}, 4'b0010);
    tick();
    for (int c = 1; c <= 5; c++) begin
      md_start = (c == 2);
      #1;
      chk($sformatf("md_c%0d", c), {busy4, done4, pc4, bb4},
          {c <= 4, c == 4, c > 4, c <= 4});
      tick();
    end
    clr();
    idex_memRead = 1; idex_rt = 5'd6; id_rt = 5'd6; branch_taken = 1;
    #1;
    chk("br_lu", {pc4, hz4, fl4, bb4}, 4'b0001);
    tick();
    idex_memRead = 0;
    #1;
    chk("br_after", {pc4, hz4, fl4, bb4}, 4'b1110);
    mem_busy = 1; idex_memRead = 1;
    #1;
    chk("mb_all", {pc4, hz4, fl4, bb4}, 4'b0000);
    do_reset();
    md_start = 1;
    tick();
    md_start = 0;
    nb = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      nb += int'(busy32);
      nd += int'(done32);
      if (done32) chk("md32_done_last", busy32 && u32.cnt_q == 0, 1);
      tick();
    end
    chk("md32_busy_cycles", nb, 32);
    chk("md32_done_pulses", nd, 1);
    do_reset();
    md_start = 1;
    tick();
    md_start = 0;
    tick();
    chk("abort_busy_before", busy32, 1);
    reset = 0;
    #1;
    chk("abort_rst_out", {pc32, hz32, fl32, bb32, busy32, done32}, 6'b001100);
    tick();
    chk("abort_busy_after", busy32, 0);
    reset = 1;
    nb = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      nb += int'(busy32);
      nd += int'(done32);
      tick();
    end
    chk("abort_no_busy", nb, 0);
    chk("abort_no_done", nd, 0);
`ifdef HZD_STATS_EN
    do_reset();
    chk("stats_reset", sc4, 0);
    idex_memRead = 1; idex_rt = 5'd5; id_rs = 5'd5;
    repeat (3) tick();
    clr();
    mem_busy = 1;
    repeat (2) tick();
    mem_busy = 0;
    #1;
    chk("stats_five", sc4, 5);
    mem_busy = 1;
    repeat (70000) @(posedge clk);
    #1;
    mem_busy = 0;
    chk("stats_sat", sc4, 16'hFFFF);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MD_CYCLES, default 32, multiply/divide latency in cycles (legal 2..63).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
REQ-004 The block SHALL have port id_rs  input  5  rs field of the instruction in ID.
REQ-005 The block SHALL have port id_rt  input  5  rt field of the instruction in ID.
REQ-006 The block SHALL have port idex_memRead  input  1  instruction in EX is a load.
REQ-007 The block SHALL have port idex_rt  input  5  destination register of the instruction in EX.
REQ-008 The block SHALL have port id_useHiLo  input  1  ID instruction reads HI/LO (mfhi/mflo/mult/div).
REQ-009 The block SHALL have port md_start  input  1  EX launches a mult/div this cycle.
REQ-010 The block SHALL have port branch_taken  input  1  branch/jump resolved taken in ID.
REQ-011 The block SHALL have port mem_busy  input  1  instruction/data memory not ready; freeze the front end.
REQ-012 The block SHALL have port pcWrite  output  1  PC update enable.
REQ-013 The block SHALL have port hzdWrite  output  1  IF/ID register write enable.
REQ-014 The block SHALL have port if_flush  output  1  zero the IF/ID register contents.
REQ-015 The block SHALL have port bubble  output  1  force zero control into ID/EX.
REQ-016 The block SHALL have port md_busy  output  1  mult/div unit is running.
REQ-017 The block SHALL have port md_done  output  1  one-cycle pulse when mult/div completes.

Function
REQ-018 The block SHALL detect load_use = idex_memRead && idex_rt != 0 && (idex_rt == id_rs || idex_rt == id_rt).
REQ-019 The block SHALL detect md_hzd = md_busy && id_useHiLo.
REQ-020 pcWrite, hzdWrite, if_flush and bubble SHALL be combinational from state and current inputs, with zero-cycle latency.
REQ-021 Priority SHALL be mem_busy > load_use > md_hzd > branch_taken > normal.
REQ-022 mem_busy=1 SHALL give pcWrite=0, hzdWrite=0, bubble=0, if_flush=0 (full freeze).
REQ-023 load_use or md_hzd (without mem_busy) SHALL give pcWrite=0, hzdWrite=0, bubble=1, if_flush=0.
REQ-024 branch_taken with no higher-priority condition SHALL give pcWrite=1, hzdWrite=1, if_flush=1, bubble=0.
REQ-025 branch_taken during any stall SHALL be suppressed; the branch re-asserts from the frozen ID stage, so no pending storage is kept.
REQ-026 The normal case SHALL give pcWrite=1, hzdWrite=1, if_flush=0, bubble=0.
REQ-027 The mult/div FSM SHALL have two states, MD_IDLE and MD_RUN, with a 6-bit down-counter cnt.
REQ-028 In MD_IDLE, md_start=1 SHALL set cnt <= MD_CYCLES-1 and the next state to MD_RUN.
REQ-029 In MD_RUN, cnt SHALL decrement each cycle; at cnt==0 the next state SHALL be MD_IDLE and md_done SHALL pulse high for exactly that cycle.
REQ-030 md_busy SHALL be 1 exactly while in MD_RUN.
REQ-031 md_start in MD_RUN SHALL be ignored: no restart and no counter reload.
REQ-032 The counter SHALL keep running while mem_busy or any stall is active.
REQ-033 md_done SHALL be registered (asserted in the cycle cnt==0 in MD_RUN) and SHALL NOT be asserted in MD_IDLE.

Reset
REQ-034 While reset==0 at posedge clk, the block SHALL set state <= MD_IDLE and cnt <= 0.
REQ-035 While reset==0, outputs SHALL be forced to pcWrite=0, hzdWrite=0, if_flush=1, bubble=1, md_busy=0, md_done=0.
REQ-036 Reset asserted during MD_RUN SHALL abort the operation with no md_done pulse.

Configuration
REQ-037 With HZD_STATS_EN defined, the block SHALL add output stall_cnt (16 bits), incrementing each non-reset cycle with hzdWrite==0 and saturating at 16'hFFFF.
REQ-038 stall_cnt SHALL clear to 0 on reset.
REQ-039 Without HZD_STATS_EN, the stall_cnt port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-040 Scenario: idex_memRead=1, idex_rt=5, id_rs=5 -> pcWrite=0, hzdWrite=0, bubble=1 in the same cycle; with idex_rt=0 -> no stall.
REQ-041 Scenario: MD_CYCLES=4, md_start pulse at cycle 0 -> md_busy high cycles 1-4, md_done high cycle 4 only; id_useHiLo=1 throughout -> bubble=1 cycles 1-4, bubble=0 cycle 5.
REQ-042 Scenario: branch_taken=1 together with load_use=1 -> if_flush=0, stall outputs; next cycle load_use=0, branch_taken=1 -> if_flush=1, pcWrite=1.
REQ-043 Scenario: mem_busy=1 together with load_use=1 and branch_taken=1 -> pcWrite=0, hzdWrite=0, bubble=0, if_flush=0.
REQ-044 Scenario: reset=0 at cycle 2 of MD_RUN (MD_CYCLES=32) -> md_busy=0 next cycle, no md_done pulse, outputs at reset values.
REQ-045 Scenario (HZD_STATS_EN): 3 load-use stalls plus 2 mem_busy cycles -> stall_cnt=5; preload near saturation, 70000 stall cycles -> stall_cnt=16'hFFFF.
